lcd_i2c_encoder: RTL and testbench
==================================

Name: lcd_i2c_encoder

Overview:
Upstream feeder for the i2c command sequencer. It accepts one HD44780 LCD transfer at a time (register-select bit plus data byte) and expands it into the 11-bit I2C command stream {cmd[2:0], data[7:0]} for a PCF8574 backpack in 4-bit mode. Each transfer becomes one complete I2C write transaction. The downstream sequencer pulls words over a valid/ready handshake and issues them to the i2c core.

Parameters:
ADDR, 7'h27, 7-bit I2C address of the PCF8574.
CMD_START, 3'h1, cmd code for I2C START.
CMD_WRITE, 3'h2, cmd code for I2C byte WRITE.
CMD_STOP, 3'h3, cmd code for I2C STOP.

Ports:
CLK  input  1  clock.
reset  input  1  synchronous, active-high reset; clock CLK.
in_valid  input  1  upstream transfer request.
in_ready  output  1  high only in IDLE; a transfer is accepted when in_valid && in_ready.
in_rs  input  1  LCD RS: 0 = instruction, 1 = data.
in_data  input  8  LCD byte.
in_nibble_only  input  1  send only in_data[7:4] (init sequence).
backlight  input  1  backlight bit, sampled at accept.
out_valid  output  1  out_cmd/out_data hold a word.
out_ready  input  1  consumer takes the word when out_valid && out_ready.
out_cmd  output  3  command code.
out_data  output  8  byte payload (0 for START/STOP).
busy  output  1  transfer in progress (state != IDLE).
done_tick  output  1  one-cycle pulse on the STOP word handshake.

Behaviour:
- Expander byte layout: {nib[3:0], BL, EN, RW=0, RS}, i.e. P7..P4 = nibble, P3 = BL, P2 = EN, P1 = 0, P0 = RS.
- On accept, latch rs, data, nibble_only and backlight. Later changes on the in_* pins have no effect until the next accept.
- States: IDLE, START, ADDR, HI_EN, HI, LO_EN, LO, STOP.
- Words emitted per state:
  - START: {CMD_START, 8'h00}
  - ADDR: {CMD_WRITE, {ADDR, 1'b0}}
  - HI_EN: {CMD_WRITE, {d[7:4], bl, 1, 0, rs}}
  - HI: same as HI_EN with EN = 0
  - LO_EN / LO: same as HI_EN / HI using d[3:0]
  - STOP: {CMD_STOP, 8'h00}
- Transitions:
  - IDLE -> START on accept.
  - Each non-IDLE state advances only on the out handshake.
  - HI -> LO_EN normally; HI -> STOP when nibble_only.
  - STOP -> IDLE.
- Word counts: a full transfer is 7 words; a nibble-only transfer is 5 words.
- Latency: accept at edge N gives out_valid = 1 with the START word from cycle N+1. After each handshake, the next word is valid the following cycle; one word per cycle is sustained while out_ready is held high.
- out_valid is 1 in every non-IDLE state and 0 in IDLE.
- Stalls: while out_valid && !out_ready, out_cmd and out_data stay stable.
- Completion: done_tick = 1 in the cycle after the STOP handshake edge, coincident with the return to IDLE. in_ready = 1 in that same cycle, so back-to-back transfers cost one bubble cycle.
- in_valid while busy: ignored and not queued; the upstream holds it.
- Reset values: in_ready = 1, out_valid = 0, out_cmd = 0, out_data = 0, busy = 0, done_tick = 0, state = IDLE, all latches 0.
- Reset mid-transfer discards the transfer without emitting STOP. Bus recovery is the i2c core's responsibility.
- Outputs are registered; there is no combinational path from out_ready to out_cmd/out_data.

Test Plan:
- Reset, then in_data=8'h41, rs=1, bl=1, nibble_only=0, out_ready=1 -> 7 consecutive words: {S,00}, {W,4E}, {W,4D}, {W,49}, {W,1D}, {W,19}, {S_P,00}; done_tick pulses once; in_ready rises with it.
- in_data=8'h30, rs=0, bl=0, nibble_only=1 -> {S,00}, {W,4E}, {W,34}, {W,30}, {S_P,00}; exactly 5 words.
- Backpressure: out_ready toggles randomly during 8'hA5 -> word sequence identical to the unstalled case; values stable across every stall cycle.
- in_valid held high while busy, with in_data changed mid-transfer -> current transfer uses the latched byte; the second transfer starts only after done_tick.
- reset asserted after the 3rd handshake -> next cycle out_valid=0, busy=0, in_ready=1; no STOP word emitted.
- Two back-to-back transfers with in_valid and out_ready held high -> 14 words total, one idle cycle between the STOP word and the second START word.

Source files
------------

// File: rtl/lcd_i2c_encoder.sv
// HD44780 transfer to PCF8574 I2C word stream (4-bit mode).
// One LCD byte or init nibble becomes one START..STOP write transaction.
module lcd_i2c_encoder #(
   parameter logic [6:0] ADDR      = 7'h27,
   parameter logic [2:0] CMD_START = 3'h1,
   parameter logic [2:0] CMD_WRITE = 3'h2,
   parameter logic [2:0] CMD_STOP  = 3'h3
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   input  logic       in_nibble_only,
   input  logic       backlight,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_cmd,
   output logic [7:0] out_data,
   output logic       busy,
   output logic       done_tick
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_HI_EN,
      S_HI, S_LO_EN, S_LO, S_STOP
   } state_t;

   state_t     state;
   state_t     adv;
   logic [7:0] d_q;
   logic       rs_q;
   logic       nib_q;
   logic       bl_q;

   // Expander byte: {nibble, BL, EN, RW=0, RS}
   function automatic logic [10:0] word_for(
      input state_t     s,
      input logic [7:0] d,
      input logic       rs_i,
      input logic       bl_i
   );
      logic [10:0] w;
      w = '0;
      case (s)
         S_START: w = {CMD_START, 8'h00};
         S_ADDR:  w = {CMD_WRITE, ADDR, 1'b0};
         S_HI_EN: w = {CMD_WRITE, d[7:4], bl_i, 1'b1, 1'b0, rs_i};
         S_HI:    w = {CMD_WRITE, d[7:4], bl_i, 1'b0, 1'b0, rs_i};
         S_LO_EN: w = {CMD_WRITE, d[3:0], bl_i, 1'b1, 1'b0, rs_i};
         S_LO:    w = {CMD_WRITE, d[3:0], bl_i, 1'b0, 1'b0, rs_i};
         S_STOP:  w = {CMD_STOP, 8'h00};
         default: w = '0;
      endcase
      return w;
   endfunction

   always_comb begin
      adv = S_IDLE;
      case (state)
         S_START: adv = S_ADDR;
         S_ADDR:  adv = S_HI_EN;
         S_HI_EN: adv = S_HI;
         S_HI:    adv = nib_q ? S_STOP : S_LO_EN;
         S_LO_EN: adv = S_LO;
         S_LO:    adv = S_STOP;
         default: adv = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= S_IDLE;
         d_q       <= '0;
         rs_q      <= 1'b0;
         nib_q     <= 1'b0;
         bl_q      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_cmd   <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done_tick <= 1'b0;
      end else begin
         done_tick <= 1'b0;
         if (state == S_IDLE) begin
            if (in_valid) begin
               d_q       <= in_data;
               rs_q      <= in_rs;
               nib_q     <= in_nibble_only;
               bl_q      <= backlight;
               state     <= S_START;
               in_ready  <= 1'b0;
               out_valid <= 1'b1;
               busy      <= 1'b1;
               out_cmd   <= CMD_START;
               out_data  <= 8'h00;
            end
         end else if (out_ready) begin
            state <= adv;
            {out_cmd, out_data} <= word_for(adv, d_q, rs_q, bl_q);
            if (adv == S_IDLE) begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done_tick <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_i2c_encoder.sv
// Bench for lcd_i2c_encoder: vector table, random transfers
// against a transaction-level model, plus stall/reset/back-to-back cases.
module tb_lcd_i2c_encoder;

   logic       CLK = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic       in_rs;
   logic [7:0] in_data;
   logic       in_nibble_only;
   logic       backlight;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_cmd;
   logic [7:0] out_data;
   logic       busy;
   logic       done_tick;

   lcd_i2c_encoder dut (
      .CLK(CLK), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_data(in_data),
      .in_nibble_only(in_nibble_only),
      .backlight(backlight),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_cmd(out_cmd), .out_data(out_data),
      .busy(busy), .done_tick(done_tick)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   logic [10:0] exp_q[$];
   logic [10:0] got[$];
   int          cyc[$];

   typedef struct {
      logic            rs;
      logic [7:0]      d;
      logic            nib;
      logic            bl;
      int              n;
      logic [6:0][10:0] w;
   } vec_t;

   vec_t vt[2];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: START, address, each nibble strobed EN=1 then EN=0, STOP
   function automatic void build(input logic rs, input logic [7:0] d,
                                 input logic nib, input logic bl);
      logic [3:0] n;
      exp_q.push_back({3'h1, 8'h00});
      exp_q.push_back({3'h2, 8'h4E});
      for (int k = 0; k < (nib ? 1 : 2); k++) begin
         n = (k == 0) ? d[7:4] : d[3:0];
         exp_q.push_back({3'h2, n, bl, 1'b1, 1'b0, rs});
         exp_q.push_back({3'h2, n, bl, 1'b0, 1'b0, rs});
      end
      exp_q.push_back({3'h3, 8'h00});
   endfunction

   task automatic start_xfer(input logic rs, input logic [7:0] d,
                             input logic nib, input logic bl);
      in_valid = 1'b1;
      in_rs = rs;
      in_data = d;
      in_nibble_only = nib;
      backlight = bl;
      tick();
   endtask

   task automatic collect(input bit rnd, input int budget);
      logic [10:0] prev;
      bit          stalled;
      bit          fin;
      got.delete();
      stalled = 0;
      fin = 0;
      prev = '0;
      for (int c = 0; c < budget && !fin; c++) begin
         if (stalled) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({out_cmd, out_data}), 32'(prev));
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         prev = {out_cmd, out_data};
         stalled = out_valid && !out_ready;
         if (out_valid && out_ready) begin
            got.push_back(prev);
            if (prev[10:8] == 3'h3) fin = 1;
         end
         tick();
         if (fin) begin
            chk("done_tick", 32'(done_tick), 32'd1);
            chk("in_ready_done", 32'(in_ready), 32'd1);
            chk("busy_done", 32'(busy), 32'd0);
         end
      end
      if (!fin) chk("stop_timeout", 32'd0, 32'd1);
   endtask

   task automatic cmp_seq(input string name);
      chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk({name, "_word"}, 32'(got[i]), 32'(exp_q[i]));
   endtask

   initial begin
      vt[0] = '{rs: 1'b1, d: 8'h41, nib: 1'b0, bl: 1'b1, n: 7,
                w: {11'h100, 11'h24E, 11'h24D, 11'h249,
                    11'h21D, 11'h219, 11'h300}};
      vt[1] = '{rs: 1'b0, d: 8'h30, nib: 1'b1, bl: 1'b0, n: 5,
                w: {11'h100, 11'h24E, 11'h234, 11'h230,
                    11'h300, 11'h000, 11'h000}};

      reset = 1'b1;
      in_valid = 1'b0;
      in_rs = 1'b0;
      in_data = '0;
      in_nibble_only = 1'b0;
      backlight = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_cmd", 32'(out_cmd), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done_tick), 32'd0);
      reset = 1'b0;
      tick();

      // Vector table
      foreach (vt[v]) begin
         start_xfer(vt[v].rs, vt[v].d, vt[v].nib, vt[v].bl);
         in_valid = 1'b0;
         chk("lat_valid", 32'(out_valid), 32'd1);
         chk("lat_start", 32'({out_cmd, out_data}), 32'h100);
         collect(0, 20);
         chk("vec_len", 32'(got.size()), 32'(vt[v].n));
         for (int i = 0; i < vt[v].n && i < got.size(); i++)
            chk("vec_word", 32'(got[i]), 32'(vt[v].w[6-i]));
         tick();
         chk("done_once", 32'(done_tick), 32'd0);
      end

      // Backpressure on 8'hA5
      start_xfer(1'b1, 8'hA5, 1'b0, 1'b1);
      in_valid = 1'b0;
      collect(1, 200);
      exp_q.delete();
      build(1'b1, 8'hA5, 1'b0, 1'b1);
      cmp_seq("a5_stall");

      // Random transfers under random backpressure
      for (int r = 0; r < 30; r++) begin
         logic       rrs, rnib, rbl;
         logic [7:0] rd;
         rrs = 1'($urandom);
         rnib = 1'($urandom);
         rbl = 1'($urandom);
         rd = 8'($urandom);
         start_xfer(rrs, rd, rnib, rbl);
         in_valid = 1'b0;
         collect(1, 200);
         exp_q.delete();
         build(rrs, rd, rnib, rbl);
         cmp_seq("rand");
         repeat ($urandom_range(0, 2)) tick();
      end

      // in_valid held while busy, inputs changed mid-transfer
      start_xfer(1'b1, 8'h41, 1'b0, 1'b1);
      in_data = 8'hFF;
      in_rs = 1'b0;
      in_nibble_only = 1'b1;
      backlight = 1'b0;
      collect(0, 20);
      exp_q.delete();
      build(1'b1, 8'h41, 1'b0, 1'b1);
      cmp_seq("held_first");
      tick();
      in_valid = 1'b0;
      chk("held_second_valid", 32'(out_valid), 32'd1);
      collect(0, 20);
      exp_q.delete();
      build(1'b0, 8'hFF, 1'b1, 1'b0);
      cmp_seq("held_second");
      tick();

      // Reset after the third handshake
      out_ready = 1'b1;
      start_xfer(1'b1, 8'h5A, 1'b0, 1'b1);
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_done", 32'(done_tick), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mid_rst_no_stop", 32'(out_valid), 32'd0);
      end

      // Back-to-back with in_valid and out_ready held high
      got.delete();
      cyc.delete();
      out_ready = 1'b1;
      start_xfer(1'b0, 8'h12, 1'b0, 1'b1);
      in_data = 8'h34;
      in_rs = 1'b1;
      for (int c = 0; c < 40 && got.size() < 14; c++) begin
         if (out_valid) begin
            got.push_back({out_cmd, out_data});
            cyc.push_back(c);
            if (got.size() > 7) in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      exp_q.delete();
      build(1'b0, 8'h12, 1'b0, 1'b1);
      build(1'b1, 8'h34, 1'b0, 1'b1);
      cmp_seq("b2b");
      if (cyc.size() >= 8) begin
         chk("b2b_first_run", 32'(cyc[6] - cyc[0]), 32'd6);
         chk("b2b_bubble", 32'(cyc[7] - cyc[6]), 32'd2);
      end else begin
         chk("b2b_count", 32'(cyc.size()), 32'd14);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
